// File: rtl/bsg_mcl_axil_stream_bridge_pkg.sv
// Shared constants for the AXI-Lite to manycore-link stream bridge: register map,
// response codes and packet geometry.
package bsg_mcl_axil_stream_bridge_pkg;

  localparam logic [11:0] ChanStride     = 12'h010;
  localparam logic [3:0]  TxDataOff      = 4'h0;
  localparam logic [3:0]  TxVacancyOff   = 4'h4;
  localparam logic [3:0]  RxDataOff      = 4'h8;
  localparam logic [3:0]  RxOccupancyOff = 4'hC;
  localparam logic [11:0] IrqEnAddr      = 12'h400;
  localparam logic [11:0] RxPendingAddr  = 12'h404;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  function automatic int unsigned words_per_pkt(input int unsigned width);
    return width / 32;
  endfunction

endpackage

// File: rtl/bsg_mcl_axil_stream_chan.sv
// One bridge channel: TX word packer feeding a packet fifo, and an RX packet fifo
// drained one 32-bit lane at a time, with word-exact vacancy/occupancy.
module bsg_mcl_axil_stream_chan
  import bsg_mcl_axil_stream_bridge_pkg::*;
#(
  parameter int unsigned fifo_width_p = 128,
  parameter int unsigned tx_els_p     = 2,
  parameter int unsigned rx_els_p     = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    tx_wr_i,
  input  logic [31:0]             tx_wdata_i,
  output logic                    tx_v_o,
  output logic [fifo_width_p-1:0] tx_data_o,
  input  logic                    tx_ready_i,
  input  logic                    rx_v_i,
  input  logic [fifo_width_p-1:0] rx_data_i,
  output logic                    rx_ready_o,
  input  logic                    rx_rd_i,
  output logic [31:0]             rx_rdata_o,
  output logic [31:0]             tx_vacancy_o,
  output logic [31:0]             rx_occupancy_o
);

  localparam int unsigned Words  = words_per_pkt(fifo_width_p);
  localparam int unsigned IdxW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned TxPtrW = (tx_els_p > 1) ? $clog2(tx_els_p) : 1;
  localparam int unsigned RxPtrW = (rx_els_p > 1) ? $clog2(rx_els_p) : 1;
  localparam int unsigned TxCntW = $clog2(tx_els_p + 1);
  localparam int unsigned RxCntW = $clog2(rx_els_p + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  typedef logic [Words-1:0][31:0] pkt_t;

  function automatic logic [TxPtrW-1:0] tx_ptr_inc(input logic [TxPtrW-1:0] p);
    return (p == TxPtrW'(tx_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RxPtrW-1:0] rx_ptr_inc(input logic [RxPtrW-1:0] p);
    return (p == RxPtrW'(rx_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- TX: pack then enqueue ----------------
  pkt_t              pack_q, pack_d;
  pkt_t              tx_mem_q [tx_els_p];
  logic [IdxW-1:0]   tx_idx_q;
  logic [TxPtrW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TxCntW-1:0] tx_cnt_q;
  logic              tx_push, tx_pop;

  // Final lane is merged combinationally so the packet enqueues on its last write.
  always_comb begin
    pack_d = pack_q;
    pack_d[tx_idx_q] = tx_wdata_i;
  end

  assign tx_push   = tx_wr_i & (tx_idx_q == LastIdx);
  assign tx_v_o    = (tx_cnt_q != '0);
  assign tx_pop    = tx_v_o & tx_ready_i;
  assign tx_data_o = tx_mem_q[tx_rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= pack_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pack_q      <= '0;
      tx_idx_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      if (tx_wr_i) begin
        pack_q   <= pack_d;
        tx_idx_q <= (tx_idx_q == LastIdx) ? '0 : tx_idx_q + 1'b1;
      end
      if (tx_push) tx_wr_ptr_q <= tx_ptr_inc(tx_wr_ptr_q);
      if (tx_pop)  tx_rd_ptr_q <= tx_ptr_inc(tx_rd_ptr_q);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  assign tx_vacancy_o = (32'(tx_els_p) - 32'(tx_cnt_q)) * 32'(Words) - 32'(tx_idx_q);

  // ---------------- RX: enqueue then unpack ----------------
  pkt_t              rx_mem_q [rx_els_p];
  logic [IdxW-1:0]   rx_idx_q;
  logic [RxPtrW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RxCntW-1:0] rx_cnt_q;
  logic              rx_push, rx_pop;

  assign rx_ready_o = reset_n_i & (rx_cnt_q != RxCntW'(rx_els_p));
  assign rx_push    = rx_v_i & rx_ready_o;
  assign rx_pop     = rx_rd_i & (rx_idx_q == LastIdx);
  assign rx_rdata_o = rx_mem_q[rx_rd_ptr_q][rx_idx_q];

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_idx_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      if (rx_rd_i) rx_idx_q <= (rx_idx_q == LastIdx) ? '0 : rx_idx_q + 1'b1;
      if (rx_push) rx_wr_ptr_q <= rx_ptr_inc(rx_wr_ptr_q);
      if (rx_pop)  rx_rd_ptr_q <= rx_ptr_inc(rx_rd_ptr_q);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  assign rx_occupancy_o = 32'(rx_cnt_q) * 32'(Words) - 32'(rx_idx_q);

endmodule

// File: rtl/bsg_mcl_axil_stream_bridge.sv
// AXI-Lite slave exposing num_chan_p TX/RX packet channels as 32-bit MMIO registers,
// with error responses in place of stalls and a maskable level RX interrupt.
module bsg_mcl_axil_stream_bridge
  import bsg_mcl_axil_stream_bridge_pkg::*;
#(
  parameter int unsigned num_chan_p   = 2,
  parameter int unsigned fifo_width_p = 128,
  parameter int unsigned tx_els_p     = 2,
  parameter int unsigned rx_els_p     = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     axil_awvalid_i,
  output logic                                     axil_awready_o,
  input  logic [31:0]                              axil_awaddr_i,
  input  logic                                     axil_wvalid_i,
  output logic                                     axil_wready_o,
  input  logic [31:0]                              axil_wdata_i,
  input  logic [3:0]                               axil_wstrb_i,
  output logic                                     axil_bvalid_o,
  output logic [1:0]                               axil_bresp_o,
  input  logic                                     axil_bready_i,
  input  logic                                     axil_arvalid_i,
  output logic                                     axil_arready_o,
  input  logic [31:0]                              axil_araddr_i,
  output logic                                     axil_rvalid_o,
  output logic [31:0]                              axil_rdata_o,
  output logic [1:0]                               axil_rresp_o,
  input  logic                                     axil_rready_i,
  output logic [num_chan_p-1:0]                    tx_v_o,
  output logic [num_chan_p-1:0][fifo_width_p-1:0]  tx_data_o,
  input  logic [num_chan_p-1:0]                    tx_ready_i,
  input  logic [num_chan_p-1:0]                    rx_v_i,
  input  logic [num_chan_p-1:0][fifo_width_p-1:0]  rx_data_i,
  output logic [num_chan_p-1:0]                    rx_ready_o,
  output logic                                     irq_o
);

  logic [num_chan_p-1:0][31:0] tx_vacancy, rx_occupancy, rx_rdata;
  logic [num_chan_p-1:0]       tx_wr, rx_rd, rx_pending;

  logic        bvalid_q, rvalid_q, irq_q;
  resp_e       bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [num_chan_p-1:0] irq_en_q;

  logic unused_bits;
  assign unused_bits = ^{axil_awaddr_i[31:12], axil_awaddr_i[1:0], axil_araddr_i[31:12],
                         axil_araddr_i[1:0], axil_wstrb_i};

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bsg_mcl_axil_stream_chan #(
      .fifo_width_p(fifo_width_p),
      .tx_els_p    (tx_els_p),
      .rx_els_p    (rx_els_p)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .tx_wr_i       (tx_wr[c]),
      .tx_wdata_i    (axil_wdata_i),
      .tx_v_o        (tx_v_o[c]),
      .tx_data_o     (tx_data_o[c]),
      .tx_ready_i    (tx_ready_i[c]),
      .rx_v_i        (rx_v_i[c]),
      .rx_data_i     (rx_data_i[c]),
      .rx_ready_o    (rx_ready_o[c]),
      .rx_rd_i       (rx_rd[c]),
      .rx_rdata_o    (rx_rdata[c]),
      .tx_vacancy_o  (tx_vacancy[c]),
      .rx_occupancy_o(rx_occupancy[c])
    );
    assign rx_pending[c] = (rx_occupancy[c] != '0);
  end

  // ---------------- Address decode ----------------
  logic [11:0] waddr, raddr, wreg, rreg;
  logic [7:0]  wchan, rchan;
  logic [3:0]  woff, roff;
  logic        wr_chan_ok, rd_chan_ok, wr_hs, rd_hs;

  assign waddr      = axil_awaddr_i[11:0];
  assign raddr      = axil_araddr_i[11:0];
  assign wreg       = {waddr[11:2], 2'b00};
  assign rreg       = {raddr[11:2], 2'b00};
  assign wchan      = 8'(waddr / ChanStride);
  assign rchan      = 8'(raddr / ChanStride);
  assign woff       = {waddr[3:2], 2'b00};
  assign roff       = {raddr[3:2], 2'b00};
  assign wr_chan_ok = (32'(wchan) < num_chan_p);
  assign rd_chan_ok = (32'(rchan) < num_chan_p);

  assign wr_hs = reset_n_i & axil_awvalid_i & axil_wvalid_i & ~bvalid_q;
  assign rd_hs = reset_n_i & axil_arvalid_i & ~rvalid_q;

  logic [31:0] wr_vac, rd_vac, rd_occ, rd_lane;

  always_comb begin
    wr_vac  = '0;
    rd_vac  = '0;
    rd_occ  = '0;
    rd_lane = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (wchan == 8'(c)) wr_vac = tx_vacancy[c];
      if (rchan == 8'(c)) begin
        rd_vac  = tx_vacancy[c];
        rd_occ  = rx_occupancy[c];
        rd_lane = rx_rdata[c];
      end
    end
  end

  resp_e wr_resp, rd_resp;
  logic  tx_wr_ok, irq_en_we, rx_rd_ok;
  logic [31:0] rd_data;

  always_comb begin
    wr_resp   = RespDecerr;
    tx_wr_ok  = 1'b0;
    irq_en_we = 1'b0;
    if (wr_chan_ok) begin
      if (woff == TxDataOff) begin
        if (wr_vac == '0) begin
          wr_resp = RespSlverr;
        end else begin
          wr_resp  = RespOkay;
          tx_wr_ok = 1'b1;
        end
      end else begin
        wr_resp = RespSlverr;
      end
    end else if (wreg == IrqEnAddr) begin
      wr_resp   = RespOkay;
      irq_en_we = 1'b1;
    end else if (wreg == RxPendingAddr) begin
      wr_resp = RespSlverr;
    end
  end

  always_comb begin
    rd_resp  = RespDecerr;
    rd_data  = '0;
    rx_rd_ok = 1'b0;
    if (rd_chan_ok) begin
      case (roff)
        TxVacancyOff: begin
          rd_resp = RespOkay;
          rd_data = rd_vac;
        end
        RxDataOff: begin
          if (rd_occ != '0) begin
            rd_resp  = RespOkay;
            rd_data  = rd_lane;
            rx_rd_ok = 1'b1;
          end else begin
            rd_resp = RespSlverr;
          end
        end
        RxOccupancyOff: begin
          rd_resp = RespOkay;
          rd_data = rd_occ;
        end
        default: rd_resp = RespSlverr;  // TX_DATA is write-only
      endcase
    end else if (rreg == IrqEnAddr) begin
      rd_resp = RespOkay;
      rd_data = 32'(irq_en_q);
    end else if (rreg == RxPendingAddr) begin
      rd_resp = RespOkay;
      rd_data = 32'(rx_pending);
    end
  end

  for (genvar c = 0; c < num_chan_p; c++) begin : g_strobe
    assign tx_wr[c] = wr_hs & tx_wr_ok & (wchan == 8'(c));
    assign rx_rd[c] = rd_hs & rx_rd_ok & (rchan == 8'(c));
  end

  // ---------------- Response and interrupt registers ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (axil_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= rd_data;
      end else if (axil_rready_i) begin
        rvalid_q <= 1'b0;
      end
      if (wr_hs && irq_en_we) irq_en_q <= axil_wdata_i[num_chan_p-1:0];
      irq_q <= |(irq_en_q & rx_pending);
    end
  end

  assign axil_awready_o = wr_hs;
  assign axil_wready_o  = wr_hs;
  assign axil_arready_o = rd_hs;
  assign axil_bvalid_o  = bvalid_q;
  assign axil_bresp_o   = bresp_q;
  assign axil_rvalid_o  = rvalid_q;
  assign axil_rresp_o   = rresp_q;
  assign axil_rdata_o   = rdata_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_bsg_mcl_axil_stream_bridge.sv
// Directed-plus-random bench for the AXI-Lite stream bridge, checked against a
// word-queue model of each channel's TX and RX buffering.
module tb_bsg_mcl_axil_stream_bridge;

  localparam int unsigned NumChan = 2;
  localparam int unsigned Width   = 128;
  localparam int unsigned TxEls   = 2;
  localparam int unsigned RxEls   = 4;
  localparam int unsigned W       = Width / 32;
  localparam logic [1:0]  Okay    = 2'b00;
  localparam logic [1:0]  Slverr  = 2'b10;
  localparam logic [1:0]  Decerr  = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, irq;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [NumChan-1:0] tx_v, tx_ready, rx_v, rx_ready;
  logic [NumChan-1:0][Width-1:0] tx_data, rx_data;

  always #5 clk = ~clk;

  bsg_mcl_axil_stream_bridge #(
    .num_chan_p  (NumChan),
    .fifo_width_p(Width),
    .tx_els_p    (TxEls),
    .rx_els_p    (RxEls)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .axil_awvalid_i(awvalid),
    .axil_awready_o(awready),
    .axil_awaddr_i (awaddr),
    .axil_wvalid_i (wvalid),
    .axil_wready_o (wready),
    .axil_wdata_i  (wdata),
    .axil_wstrb_i  (wstrb),
    .axil_bvalid_o (bvalid),
    .axil_bresp_o  (bresp),
    .axil_bready_i (bready),
    .axil_arvalid_i(arvalid),
    .axil_arready_o(arready),
    .axil_araddr_i (araddr),
    .axil_rvalid_o (rvalid),
    .axil_rdata_o  (rdata),
    .axil_rresp_o  (rresp),
    .axil_rready_i (rready),
    .tx_v_o        (tx_v),
    .tx_data_o     (tx_data),
    .tx_ready_i    (tx_ready),
    .rx_v_i        (rx_v),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .irq_o         (irq)
  );

  int ncmp = 0;
  int nerr = 0;
  int rx_hs0 = 0;
  logic [31:0] tx_q [NumChan][$];
  logic [31:0] rx_q [NumChan][$];

  always @(posedge clk) if (rx_v[0] && rx_ready[0]) rx_hs0 <= rx_hs0 + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_check(input string tag, input int n, input int lim);
    ncmp++;
    assert (n < lim) else begin
      nerr++;
      $error("FAIL %s: observed %0d cycles, expected under %0d", tag, n, lim);
    end
  endtask

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = 4'hF;
    #1; n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
    bound_check("aw/w handshake", n, 50);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    bound_check("b response", n, 50);
    r = bresp;
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    #1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    bound_check("ar handshake", n, 50);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk); n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    bound_check("r response", n, 50);
    d = rdata; r = rresp;
  endtask

  task automatic tx_write(input int c, input logic [31:0] d);
    logic [1:0] r, er;
    int vac;
    vac = int'(TxEls * W) - tx_q[c].size();
    er = (vac > 0) ? Okay : Slverr;
    axil_write(32'(c * 16), d, r);
    check("tx write bresp", 128'(r), 128'(er));
    if (er == Okay) tx_q[c].push_back(d);
  endtask

  task automatic tx_drain_one(input int c);
    logic [127:0] pkt;
    logic [31:0] tmp;
    @(negedge clk);
    for (int i = 0; i < int'(W); i++) pkt[i*32 +: 32] = tx_q[c][i];
    check("tx_v before pop", 128'(tx_v[c]), 128'(1));
    check("tx_data packet", tx_data[c], pkt);
    tx_ready[c] = 1'b1;
    @(posedge clk); #1;
    tx_ready[c] = 1'b0;
    for (int i = 0; i < int'(W); i++) tmp = tx_q[c].pop_front();
  endtask

  task automatic rx_push(input int c, input logic [127:0] pkt);
    int n;
    @(negedge clk);
    rx_v[c] = 1'b1; rx_data[c] = pkt;
    #1; n = 0;
    while (!rx_ready[c] && n < 50) begin @(negedge clk); #1; n++; end
    bound_check("rx push handshake", n, 50);
    @(posedge clk); #1;
    rx_v[c] = 1'b0;
    for (int i = 0; i < int'(W); i++) rx_q[c].push_back(pkt[i*32 +: 32]);
  endtask

  task automatic rx_read_chk(input int c);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    if (rx_q[c].size() == 0) begin ed = '0; er = Slverr; end
    else begin ed = rx_q[c].pop_front(); er = Okay; end
    axil_read(32'(c * 16 + 8), d, r);
    check("rx_data word", 128'(d), 128'(ed));
    check("rx_data rresp", 128'(r), 128'(er));
  endtask

  task automatic vac_chk(input int c);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(32'(c * 16 + 4), d, r);
    check("tx_vacancy", 128'(d), 128'(int'(TxEls * W) - tx_q[c].size()));
    check("tx_vacancy rresp", 128'(r), 128'(Okay));
  endtask

  task automatic occ_chk(input int c);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(32'(c * 16 + 12), d, r);
    check("rx_occupancy", 128'(d), 128'(rx_q[c].size()));
    check("rx_occupancy rresp", 128'(r), 128'(Okay));
  endtask

  function automatic logic [127:0] rand_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [31:0]  d, exp_last;
    logic [1:0]   r;
    logic [127:0] pkt;
    int           hs_before;

    // Valids held high during reset: readies must stay low regardless.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = '0; araddr = '0;
    wdata = '0; wstrb = 4'hF; bready = 1'b1; rready = 1'b1;
    tx_ready = '0; rx_v = '1; rx_data = '0;
    repeat (3) @(negedge clk);
    check("reset awready", 128'(awready), 128'(0));
    check("reset wready", 128'(wready), 128'(0));
    check("reset arready", 128'(arready), 128'(0));
    check("reset bvalid", 128'(bvalid), 128'(0));
    check("reset rvalid", 128'(rvalid), 128'(0));
    check("reset rdata", 128'(rdata), 128'(0));
    check("reset bresp", 128'(bresp), 128'(0));
    check("reset rresp", 128'(rresp), 128'(0));
    check("reset tx_v", 128'(tx_v), 128'(0));
    check("reset rx_ready", 128'(rx_ready), 128'(0));
    check("reset irq", 128'(irq), 128'(0));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rx_v = '0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("rx_ready after reset", 128'(rx_ready), 128'(2'b11));

    // 1: pack four words into one packet on channel 0.
    tx_write(0, 32'h11); tx_write(0, 32'h22); tx_write(0, 32'h33); tx_write(0, 32'h44);
    @(negedge clk);
    check("tx_v after 4 words", 128'(tx_v[0]), 128'(1));
    check("tx_data lane order", tx_data[0], 128'h00000044_00000033_00000022_00000011);
    vac_chk(0);
    tx_drain_one(0);
    @(negedge clk);
    check("tx_v after drain", 128'(tx_v[0]), 128'(0));

    // 2: overfill the TX buffer with random words.
    for (int i = 0; i < 9; i++) tx_write(0, $urandom);
    vac_chk(0);
    tx_drain_one(0);
    tx_drain_one(0);
    vac_chk(0);

    // 3: unpack a single packet on channel 1.
    rx_push(1, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});
    occ_chk(1);
    for (int i = 0; i < 5; i++) rx_read_chk(1);

    // 4: fill channel 0 RX, then pop the last lane while a new packet waits.
    for (int i = 0; i < int'(RxEls); i++) rx_push(0, rand_pkt());
    @(negedge clk);
    check("rx_ready when full", 128'(rx_ready[0]), 128'(0));
    occ_chk(0);
    for (int i = 0; i < int'(W) - 1; i++) rx_read_chk(0);
    exp_last  = rx_q[0][0];
    hs_before = rx_hs0;
    pkt       = rand_pkt();
    fork
      axil_read(32'h8, d, r);
      rx_push(0, pkt);
    join
    check("last lane data", 128'(d), 128'(exp_last));
    check("last lane rresp", 128'(r), 128'(Okay));
    exp_last = rx_q[0].pop_front();
    check("rx handshakes while full", 128'(rx_hs0 - hs_before), 128'(1));
    occ_chk(0);
    for (int i = 0; i < int'(RxEls * W) + 1; i++) rx_read_chk(0);

    // 5: interrupt masking and latency.
    axil_write(32'h400, 32'h2, r);
    check("irq_en bresp", 128'(r), 128'(Okay));
    axil_read(32'h400, d, r);
    check("irq_en readback", 128'(d), 128'(2));
    rx_push(0, rand_pkt());
    repeat (3) @(negedge clk);
    check("irq masked ch0", 128'(irq), 128'(0));
    rx_push(1, rand_pkt());
    check("irq one cycle after push", 128'(irq), 128'(0));
    @(posedge clk); #1;
    check("irq two cycles after push", 128'(irq), 128'(1));
    axil_read(32'h404, d, r);
    check("rx_pending", 128'(d), 128'(2'b11));
    for (int i = 0; i < int'(W); i++) rx_read_chk(1);
    repeat (2) @(negedge clk);
    check("irq after ch1 drain", 128'(irq), 128'(0));
    for (int i = 0; i < int'(W); i++) rx_read_chk(0);
    check("irq after ch0 drain", 128'(irq), 128'(0));

    // 6: decode errors, then asynchronous reset mid-packet.
    axil_read(32'h020, d, r);
    check("decerr rdata", 128'(d), 128'(0));
    check("decerr rresp", 128'(r), 128'(Decerr));
    axil_write(32'h800, $urandom, r);
    check("decerr bresp", 128'(r), 128'(Decerr));
    axil_write(32'h004, $urandom, r);
    check("read-only write bresp", 128'(r), 128'(Slverr));
    for (int i = 0; i < int'(W) + 2; i++) tx_write(0, $urandom);
    rx_push(1, rand_pkt());
    vac_chk(0);
    check("irq before reset", 128'(irq), 128'(1));
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async reset tx_v", 128'(tx_v), 128'(0));
    check("async reset irq", 128'(irq), 128'(0));
    check("async reset rx_ready", 128'(rx_ready), 128'(0));
    check("async reset rdata", 128'(rdata), 128'(0));
    for (int c = 0; c < int'(NumChan); c++) begin
      tx_q[c].delete();
      rx_q[c].delete();
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vac_chk(0);
    occ_chk(1);
    axil_read(32'h400, d, r);
    check("irq_en after reset", 128'(d), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
